uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one uart_send transmitter between N byte sources, for example the loopback echo path, a status reporter and a debug dumper.
- Accepts bytes from requesters over valid/ready handshakes.
- Fires the transmitter's one-cycle uart_en / uart_data strobe.
- Sequences each frame by watching the transmitter busy flag.
- Sits between the requesters and uart_send in the UART top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, grant index width; must equal ceil(log2(NUM_REQ)), minimum 1
START_TMO, 16, clk cycles allowed after uart_en for uart_busy to rise before a start-timeout is flagged

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  NUM_REQ  last byte of a packet (used only with the optional feature)
req_ready  output  NUM_REQ  one-hot accept pulse; the byte is taken on this cycle
uart_en  output  1  one-cycle transmit strobe to uart_send
uart_data  output  8  byte to uart_send; stable from the uart_en cycle until the frame ends
uart_busy  input  1  transmitter busy flag, high for the whole frame
grant_id  output  ID_W  index of the currently or last granted requester
grant_valid  output  1  high from the accept cycle until the frame completes
err_tmo  output  1  one-cycle pulse on start-timeout
byte_cnt  output  16  count of bytes completed; wraps at 65535 -> 0

Behaviour:
- Reset (asynchronous, active-high) forces:
  - all outputs to 0;
  - state to IDLE;
  - round-robin pointer to 0, so requester 0 has highest priority first;
  - internal timeout counter to 0.
- States and transitions:
  - IDLE: if any req_valid is high, go to GRANT in the same cycle the valid is seen.
  - GRANT:
    - Pick the first valid requester scanning from pointer, pointer+1, ... mod NUM_REQ.
    - Pulse its req_ready for 1 cycle, latch its req_data into uart_data, set grant_id and grant_valid.
    - Go to FIRE.
  - FIRE: uart_en=1 for exactly 1 cycle, clear the timeout counter, go to WAIT_START.
  - WAIT_START:
    - If uart_busy=1, go to WAIT_DONE.
    - Else increment the counter; when it reaches START_TMO, pulse err_tmo, clear grant_valid, go to IDLE. byte_cnt does not change.
  - WAIT_DONE:
    - On uart_busy=0, increment byte_cnt, clear grant_valid, set pointer = grant_id+1 mod NUM_REQ, go to IDLE.
- Latency: req_valid seen in IDLE -> req_ready 1 cycle later -> uart_en 1 cycle after that.
  - Back-to-back frames have 2 idle cycles between uart_busy falling and the next uart_en.
- Handshake: a requester holds req_valid and req_data stable until it sees req_ready.
  - Dropping req_valid before the grant is allowed; that requester is simply skipped.
- Simultaneous requests: only one req_ready per grant.
  - Fairness: with all NUM_REQ valid continuously, the grant order is 0,1,2,3,0,...
- uart_busy already high in IDLE (a stale frame): arbitration still proceeds; WAIT_START is satisfied immediately.
- uart_busy high in FIRE is ignored.
- Reset mid-frame: the arbiter returns to IDLE at once, and uart_en does not re-fire.
  - The transmitter is reset by the same rst at the top level.

Optional Feature:
UART_ARB_LOCK_EN
- Defined:
  - After a frame completes, if the byte just sent had req_last=0, the pointer stays on grant_id.
  - Only that requester is served until it sends a byte with req_last=1; other req_valid inputs are ignored meanwhile.
  - While locked, if the owner drops req_valid, the arbiter waits in IDLE with no timeout.
  - A start-timeout releases the lock.
- Undefined: req_last is ignored and every byte is arbitrated independently; the module otherwise behaves identically.

Test Plan:
- Single byte: req_valid[1]=1, req_data[15:8]=8'hA5; uart_busy modelled high 3..12 cycles after uart_en -> req_ready=4'b0010 once, uart_en once with uart_data=8'hA5, grant_id=1, byte_cnt 0->1.
- Fairness: all four valid with bytes 8'h10/8'h20/8'h30/8'h40 held for 8 frames -> uart_data sequence 10,20,30,40,10,20,30,40.
- Timeout: uart_busy tied 0, req_valid[2]=1 -> err_tmo pulses exactly START_TMO+1 cycles after uart_en, byte_cnt stays 0, grant_valid=0, next grant proceeds normally.
- Reset in WAIT_DONE: assert rst for 1 cycle mid-frame -> all outputs 0, pointer 0; requesters 0 and 3 valid afterwards -> requester 0 is granted first.
- Wrap: preload via 65535 frames, or force byte_cnt=16'hFFFF -> the next completed frame gives byte_cnt=16'h0000.
- With UART_ARB_LOCK_EN: requester 2 sends 3 bytes with req_last=0,0,1 while requester 0 is valid -> order 2,2,2,0; without the macro -> order 2,0,2,0,2.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one uart_send transmitter between NUM_REQ byte sources.
// Ports: clk/rst (async active-high); req_valid/req_data/req_last in, req_ready one-hot accept out;
// uart_en/uart_data strobe to uart_send, uart_busy back; grant_id/grant_valid, err_tmo, byte_cnt status.
// Optional packet lock: define UART_ARB_LOCK_EN to keep serving one requester until req_last=1.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int START_TMO = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_en,
    output logic [7:0]           uart_data,
    input  logic                 uart_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 grant_valid,
    output logic                 err_tmo,
    output logic [15:0]          byte_cnt
);
    localparam int TW = $clog2(START_TMO + 1);

    typedef enum logic [2:0] {IDLE, GRANT, FIRE, WAIT_START, WAIT_DONE} state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr, pick, idx, ptr_next;
    logic [ID_W:0]     sum;
    logic [TW-1:0]     tmo_cnt;
    logic [NUM_REQ-1:0] cand;
    logic              any;

`ifdef UART_ARB_LOCK_EN
    logic locked, last_q;
    // while locked only the owner of the open packet may be picked
    assign cand = locked ? req_valid & (NUM_REQ'(1) << grant_id) : req_valid;
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign cand = req_valid;
`endif

    assign ptr_next = grant_id == ID_W'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;

    // scan downward so the requester closest to ptr is the one left in pick
    always_comb begin
        pick = ptr;
        any  = 1'b0;
        sum  = '0;
        idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            idx = sum >= (ID_W + 1)'(NUM_REQ) ? ID_W'(sum - (ID_W + 1)'(NUM_REQ)) : ID_W'(sum);
            if (cand[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

    // the pick is registered on the IDLE edge so req_ready is visible during GRANT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            tmo_cnt     <= '0;
            req_ready   <= '0;
            uart_en     <= 1'b0;
            uart_data   <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            err_tmo     <= 1'b0;
            byte_cnt    <= '0;
`ifdef UART_ARB_LOCK_EN
            locked      <= 1'b0;
            last_q      <= 1'b0;
`endif
        end else begin
            req_ready <= '0;
            uart_en   <= 1'b0;
            err_tmo   <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    req_ready   <= NUM_REQ'(1) << pick;
                    uart_data   <= req_data[8*pick +: 8];
                    grant_id    <= pick;
                    grant_valid <= 1'b1;
`ifdef UART_ARB_LOCK_EN
                    last_q      <= req_last[pick];
`endif
                    state       <= GRANT;
                end
                GRANT: begin
                    uart_en <= 1'b1;
                    state   <= FIRE;
                end
                FIRE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_START;
                end
                WAIT_START: begin
                    if (uart_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmo_cnt == TW'(START_TMO - 1)) begin
                        err_tmo     <= 1'b1;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
`ifdef UART_ARB_LOCK_EN
                        locked      <= 1'b0;
`endif
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: if (!uart_busy) begin
                    byte_cnt    <= byte_cnt + 1'b1;
                    grant_valid <= 1'b0;
                    state       <= IDLE;
`ifdef UART_ARB_LOCK_EN
                    locked      <= !last_q;
                    ptr         <= last_q ? ptr_next : grant_id;
`else
                    ptr         <= ptr_next;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
